// File: rtl/spi_cfg_pkg.sv
// Shared constants, request record and FSM encoding for the SPI configuration controller.
package spi_cfg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam logic        WRITE_BIT  = 1'b1;

    localparam logic [6:0] REG_EN_OUT_LO = 7'h00;
    localparam logic [6:0] REG_EN_OUT_HI = 7'h01;
    localparam logic [6:0] REG_EN_PWM_LO = 7'h02;
    localparam logic [6:0] REG_EN_PWM_HI = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY  = 7'h04;
    localparam logic [6:0] MAX_ADDR      = REG_PWM_DUTY;

    // Phase counter must hold 2*CLK_DIV-1 for CLK_DIV up to 255.
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned BIT_CNT_W = 5;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } cfg_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic logic [FRAME_BITS-1:0] frame_word(input cfg_req_t req);
        return {WRITE_BIT, req.addr, req.data};
    endfunction

endpackage

// File: rtl/spi_cfg_controller_fifo.sv
// Request FIFO for the SPI configuration controller: power-of-two depth, 15-bit entries.
module cfg_req_fifo
    import spi_cfg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  cfg_req_t wdata_i,
    input  logic     pop_i,
    output cfg_req_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    cfg_req_t      mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spi_cfg_controller.sv
// Buffers register-write requests and serialises each one as a 16-bit SPI mode-0 write frame.
module spi_cfg_controller
    import spi_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [6:0]  MAX_ADDR   = spi_cfg_pkg::MAX_ADDR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       spi_sclk,
    output logic       spi_copi,
    output logic       spi_cs,
    output logic       busy,
    output logic       frame_done,
    output logic       bad_addr
);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    cfg_req_t        fifo_wdata, fifo_rdata;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0]     head_word;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]  bits_q, bits_d;
    logic [15:0]           shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  copi_q, copi_d;
    logic                  cs_q, cs_d;
    logic                  done_q, done_d;
    logic                  bad_q;
    logic                  pend_q;
    logic                  cnt_zero;

    assign req_ready  = !fifo_full;
    assign fifo_push  = req_valid && !fifo_full;
    assign fifo_wdata = '{addr: req_addr, data: req_data};
    assign head_word  = frame_word(fifo_rdata);
    assign cnt_zero   = (cnt_q == '0);

    cfg_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bits_d   = bits_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        copi_d   = copi_q;
        cs_d     = cs_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // pend_q is a registered copy of !empty; it keeps the FIFO flag off the pop path.
                if (pend_q) begin
                    fifo_pop = 1'b1;
                    shreg_d  = head_word;
                    copi_d   = head_word[15];
                    bits_d   = BIT_CNT_W'(FRAME_BITS);
                    cs_d     = 1'b0;
                    cnt_d    = DIV_LAST;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_LAST;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    sclk_d = 1'b0;
                    bits_d = bits_q - 1'b1;
                    if (bits_q != BIT_CNT_W'(1)) begin
                        shreg_d = shreg_q << 1;
                        copi_d  = shreg_q[14];
                        cnt_d   = DIV_LAST;
                        state_d = ST_LOW;
                    end else begin
                        // Final low phase and CS hold run back to back: CS low for 34 half-periods.
                        cnt_d   = HOLD_LAST;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_zero) begin
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_LAST;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = GAP_LAST;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
            pend_q  <= !fifo_empty;
            if (fifo_push && (req_addr > MAX_ADDR)) bad_q <= 1'b1;
        end
    end

    assign spi_sclk   = sclk_q;
    assign spi_copi   = copi_q;
    assign spi_cs     = cs_q;
    assign frame_done = done_q;
    assign bad_addr   = bad_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Bench for spi_cfg_controller: a cycle-level schedule model predicts handshake, busy and frame
// start times, while a pin-level peripheral model decodes frames and checks SPI timing.
module tb_spi_cfg_controller;

    localparam int D      = 4;
    localparam int G      = 8;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 34 * D;
    localparam int PERIOD = FRAME + G + 1;
    localparam logic [6:0] MAXA = 7'h04;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, spi_sclk, spi_copi, spi_cs, busy, frame_done, bad_addr;

    spi_cfg_controller #(
        .CLK_DIV    (D),
        .GAP_CYCLES (G),
        .FIFO_DEPTH (DEPTH),
        .MAX_ADDR   (MAXA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .spi_sclk   (spi_sclk),
        .spi_copi   (spi_copi),
        .spi_cs     (spi_cs),
        .busy       (busy),
        .frame_done (frame_done),
        .bad_addr   (bad_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- schedule model ----------------
    typedef struct {
        int         end_c;
        logic [6:0] a;
        logic [7:0] d;
    } pend_t;

    int          starts[$];
    logic [15:0] mwords[$];
    pend_t       pq[$];
    logic        mbad = 1'b0;
    logic [7:0]  exp_regs [5] = '{default: 8'h00};

    function automatic int occ(input int k);
        int n = 0;
        foreach (starts[i]) if (starts[i] > k) n++;
        return n;
    endfunction

    function automatic logic mbusy(input int k);
        if (occ(k) > 0) return 1'b1;
        foreach (starts[i]) if (starts[i] <= k && k < starts[i] + FRAME + G) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- pin-level peripheral model ----------------
    logic [7:0]  periph [5] = '{default: 8'h00};
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;
    logic        cs_fell, cs_rose, sclk_rise, sclk_fall;
    logic        in_frame = 1'b0, had_rise = 1'b0;
    logic [15:0] sword = '0, last_word = '0;
    int          rises = 0, frame_idx = 0, frames_seen = 0;
    int          fstart = 0, last_sclk = 0, last_copi = 0, last_rise = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame  = 1'b0;
                had_rise  = 1'b0;
                frame_idx = 0;
                rises     = 0;
            end else begin
                cs_fell   = p_cs && !spi_cs;
                cs_rose   = !p_cs && spi_cs;
                sclk_rise = !p_sclk && spi_sclk;
                sclk_fall = p_sclk && !spi_sclk;
                if (cs_rose || frame_done) chk("frame_done", frame_done, cs_rose);
                if (spi_cs && spi_sclk) chk("sclk_idle_low", spi_sclk, 1'b0);
                if (spi_copi != p_copi) begin
                    chk("copi_change_edge", sclk_fall || cs_fell, 1'b1);
                    last_copi = cyc;
                end
                if (cs_fell) begin
                    if (had_rise) chk("cs_gap_min", (cyc - last_rise) >= G + 1, 1'b1);
                    chk("frame_expected", frame_idx < starts.size(), 1'b1);
                    in_frame  = 1'b1;
                    fstart    = cyc;
                    rises     = 0;
                    sword     = '0;
                    last_sclk = cyc;
                end
                if (in_frame && sclk_rise) begin
                    chk("sclk_low_len", cyc - last_sclk, D);
                    chk("copi_setup", (cyc - last_copi) >= D, 1'b1);
                    rises++;
                    sword     = {sword[14:0], spi_copi};
                    last_sclk = cyc;
                end
                if (in_frame && sclk_fall) begin
                    chk("sclk_high_len", cyc - last_sclk, D);
                    last_sclk = cyc;
                end
                if (in_frame && cs_rose) begin
                    chk("cs_low_len", cyc - fstart, FRAME);
                    chk("sclk_rises", rises, 16);
                    if (frame_idx < mwords.size()) begin
                        chk("frame_word", sword, mwords[frame_idx]);
                        chk("frame_start", fstart, starts[frame_idx]);
                    end
                    if (rises == 16 && sword[15] && sword[14:8] <= MAXA)
                        periph[int'(sword[14:8])] = sword[7:0];
                    frame_idx++;
                    frames_seen++;
                    last_word = sword;
                    last_rise = cyc;
                    had_rise  = 1'b1;
                    in_frame  = 1'b0;
                end
            end
            p_cs   = spi_cs;
            p_sclk = spi_sclk;
            p_copi = spi_copi;
        end
    end

    // One clock cycle: check held outputs against the model, drive, clock, update the model.
    task automatic step(input logic v, input logic [6:0] a, input logic [7:0] d);
        logic  acc;
        int    s;
        pend_t p;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        chk("req_ready", req_ready, occ(cyc) < DEPTH);
        chk("busy", busy, mbusy(cyc));
        chk("bad_addr", bad_addr, mbad);
        acc = v && (occ(cyc) < DEPTH);
        @(posedge clk);
        #1;
        if (acc) begin
            s = cyc + 2;
            if (starts.size() > 0 && starts[$] + PERIOD > s) s = starts[$] + PERIOD;
            starts.push_back(s);
            mwords.push_back({1'b1, a, d});
            if (a > MAXA) mbad = 1'b1;
            p.end_c = s + FRAME;
            p.a     = a;
            p.d     = d;
            pq.push_back(p);
        end
        while (pq.size() > 0 && pq[0].end_c <= cyc) begin
            if (pq[0].a <= MAXA) exp_regs[int'(pq[0].a)] = pq[0].d;
            void'(pq.pop_front());
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 3000 && (mbusy(cyc) || in_frame)) begin
            step(1'b0, 7'h00, 8'h00);
            n++;
        end
        chk("drain_in_budget", n < 3000, 1'b1);
        repeat (2) step(1'b0, 7'h00, 8'h00);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 5; i++) chk("periph_reg", periph[i], exp_regs[i]);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] word;
        logic        bad;
    } vec_t;

    vec_t       tbl [6];
    int         n, f0;
    logic       v, ok;
    logic [6:0] ra;
    logic [7:0] rd;

    initial begin
        tbl[0] = '{7'h04, 8'hA5, 16'h84A5, 1'b0};
        tbl[1] = '{7'h00, 8'h3C, 16'h803C, 1'b0};
        tbl[2] = '{7'h7F, 8'hFF, 16'hFFFF, 1'b1};
        tbl[3] = '{7'h02, 8'h5A, 16'h825A, 1'b1};
        tbl[4] = '{7'h05, 8'h01, 16'h8501, 1'b1};
        tbl[5] = '{7'h03, 8'hC3, 16'h83C3, 1'b1};

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_cs", spi_cs, 1'b1);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_copi", spi_copi, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_bad_addr", bad_addr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        rst_n = 1'b1;

        // Single writes, one at a time, against fixed expected frame words.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].addr, tbl[i].data);
            drain();
            chk("tbl_frame_word", last_word, tbl[i].word);
            chk("tbl_bad_addr", bad_addr, tbl[i].bad);
        end
        check_regs();
        chk("duty_reg", periph[4], 8'hA5);

        // Burst of five back to back; FIFO back-pressure checked every cycle.
        n = 0;
        for (int t = 0; t < 400 && n < 5; t++) begin
            ok = occ(cyc) < DEPTH;
            step(1'b1, 7'(n), 8'(8'h11 * (n + 1)));
            if (ok) n++;
        end
        chk("burst_accepts", n, 5);
        drain();
        check_regs();
        chk("burst_reg4", periph[4], 8'h55);

        // Push arriving while the previous frame is in its gap.
        step(1'b1, 7'h01, 8'h42);
        f0 = frames_seen;
        for (int t = 0; t < 400 && frames_seen == f0; t++) step(1'b0, 7'h00, 8'h00);
        chk("gap_first_frame", frames_seen > f0, 1'b1);
        repeat (3) step(1'b0, 7'h00, 8'h00);
        step(1'b1, 7'h02, 8'h24);
        drain();
        check_regs();

        // Randomised traffic with occasional out-of-range addresses.
        n = 0;
        for (int t = 0; t < 8000 && n < 20; t++) begin
            v  = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            rd = 8'($urandom);
            ok = v && (occ(cyc) < DEPTH);
            step(v, ra, rd);
            if (ok) n++;
        end
        chk("random_accepts", n, 20);
        drain();
        check_regs();

        // Reset after the 7th sclk rise of a frame with two more queued behind it.
        step(1'b1, 7'h03, 8'h77);
        step(1'b1, 7'h01, 8'h99);
        step(1'b1, 7'h02, 8'h66);
        for (int t = 0; t < 400 && !(in_frame && rises >= 7); t++) step(1'b0, 7'h00, 8'h00);
        chk("reached_7th_rise", in_frame && rises >= 7, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", spi_cs, 1'b1);
        chk("midrst_sclk", spi_sclk, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        starts.delete();
        mwords.delete();
        pq.delete();
        mbad = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = frames_seen;
        repeat (PERIOD + 20) step(1'b0, 7'h00, 8'h00);
        chk("no_frame_after_flush", frames_seen, f0);
        check_regs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
